// File: rtl/exu_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight; busy while iterating, single-cycle writeback pulse.
module exu_div #(
  parameter int unsigned XLEN                = 32,
  parameter int unsigned REG_FILE_ADDR_WIDTH = 5,
  parameter int unsigned TAG_WIDTH           = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pipe_flush,
  input  logic                           div_valid,
  input  logic                           div_rem,
  input  logic                           div_unsign,
  input  logic [XLEN-1:0]                div_rs1_data,
  input  logic [XLEN-1:0]                div_rs2_data,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] div_rd_addr,
  input  logic [TAG_WIDTH-1:0]           div_instr_tag,
  output logic                           div_busy,
  output logic                           div_wb_valid,
  output logic [XLEN-1:0]                div_wb_data,
  output logic [REG_FILE_ADDR_WIDTH-1:0] div_wb_rd_addr,
  output logic [TAG_WIDTH-1:0]           div_wb_instr_tag
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] One    = XLEN'(1);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                         state_q;
  logic [CntW-1:0]                count_q;
  logic [XLEN-1:0]                r_q;
  logic [XLEN-1:0]                q_q;
  logic [XLEN-1:0]                dvsr_q;
  logic                           q_neg_q;
  logic                           r_neg_q;
  logic                           rem_q;
  logic [REG_FILE_ADDR_WIDTH-1:0] op_rd_q;
  logic [TAG_WIDTH-1:0]           op_tag_q;
  logic                           wb_valid_q;
  logic [XLEN-1:0]                wb_data_q;
  logic [REG_FILE_ADDR_WIDTH-1:0] wb_rd_q;
  logic [TAG_WIDTH-1:0]           wb_tag_q;

  logic            rs1_neg, rs2_neg, overflow;
  logic [XLEN-1:0] dvd_abs, dvs_abs;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] diff, r_nxt, q_nxt, quot_fin, rem_fin;
  logic            ge;

  always_comb begin
    rs1_neg  = ~div_unsign & div_rs1_data[XLEN-1];
    rs2_neg  = ~div_unsign & div_rs2_data[XLEN-1];
    dvd_abs  = rs1_neg ? (~div_rs1_data + One) : div_rs1_data;
    dvs_abs  = rs2_neg ? (~div_rs2_data + One) : div_rs2_data;
    overflow = ~div_unsign && (div_rs1_data == MinInt) && (div_rs2_data == '1);

    // One restoring step: shift next dividend bit into the partial remainder.
    trial    = {r_q, q_q[XLEN-1]};
    ge       = trial >= {1'b0, dvsr_q};
    diff     = trial[XLEN-1:0] - dvsr_q;
    r_nxt    = ge ? diff : trial[XLEN-1:0];
    q_nxt    = {q_q[XLEN-2:0], ge};
    quot_fin = q_neg_q ? (~q_nxt + One) : q_nxt;
    rem_fin  = r_neg_q ? (~r_nxt + One) : r_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      r_q        <= '0;
      q_q        <= '0;
      dvsr_q     <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      rem_q      <= 1'b0;
      op_rd_q    <= '0;
      op_tag_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_tag_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          wb_valid_q <= 1'b0;
          if (div_valid && !pipe_flush) begin
            rem_q    <= div_rem;
            op_rd_q  <= div_rd_addr;
            op_tag_q <= div_instr_tag;
            if (div_rs2_data == '0) begin
              state_q    <= StDone;
              wb_valid_q <= 1'b1;
              wb_data_q  <= div_rem ? div_rs1_data : '1;
              wb_rd_q    <= div_rd_addr;
              wb_tag_q   <= div_instr_tag;
            end else if (overflow) begin
              state_q    <= StDone;
              wb_valid_q <= 1'b1;
              wb_data_q  <= div_rem ? '0 : MinInt;
              wb_rd_q    <= div_rd_addr;
              wb_tag_q   <= div_instr_tag;
            end else begin
              state_q <= StCalc;
              count_q <= '0;
              r_q     <= '0;
              q_q     <= dvd_abs;
              dvsr_q  <= dvs_abs;
              q_neg_q <= rs1_neg ^ rs2_neg;
              r_neg_q <= rs1_neg;
            end
          end
        end
        StCalc: begin
          if (pipe_flush) begin
            state_q <= StIdle;
          end else begin
            r_q     <= r_nxt;
            q_q     <= q_nxt;
            count_q <= count_q + CntW'(1);
            if (count_q == LastCnt) begin
              state_q    <= StDone;
              wb_valid_q <= 1'b1;
              wb_data_q  <= rem_q ? rem_fin : quot_fin;
              wb_rd_q    <= op_rd_q;
              wb_tag_q   <= op_tag_q;
            end
          end
        end
        StDone: begin
          wb_valid_q <= 1'b0;
          state_q    <= StIdle;
        end
        default: begin
          wb_valid_q <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign div_busy         = (state_q == StCalc);
  // A flush landing in the writeback cycle squashes the pulse.
  assign div_wb_valid     = wb_valid_q & ~pipe_flush;
  assign div_wb_data      = wb_data_q;
  assign div_wb_rd_addr   = wb_rd_q;
  assign div_wb_instr_tag = wb_tag_q;

endmodule

// File: doc/exu_div.md
# exu_div

Iterative radix-2 integer divider in the execute unit, covering RV32M DIV/DIVU/REM/REMU. It consumes issued divide operations from the IDU1 → EXU interface (legal & div), holds `exu_div_busy` while iterating so IDU1 stalls, and returns one writeback beat (data, rd, tag) to the EXU writeback mux. Non-pipelined: one operation in flight.

## Interface
- XLEN, 32, datapath width
- REG_FILE_ADDR_WIDTH, 5, rd address width
- TAG_WIDTH, 8, instruction tag width
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- pipe_flush  in  1  abort in-flight op, discard result
- div_valid  in  1  issue strobe (idu1_out.legal & idu1_out.div)
- div_rem  in  1  1 = REM/REMU, 0 = DIV/DIVU
- div_unsign  in  1  1 = DIVU/REMU
- div_rs1_data  in  XLEN  dividend
- div_rs2_data  in  XLEN  divisor
- div_rd_addr  in  REG_FILE_ADDR_WIDTH  destination
- div_instr_tag  in  TAG_WIDTH  tag
- div_busy  out  1  op in flight (drives exu_div_busy)
- div_wb_valid  out  1  one-cycle writeback pulse
- div_wb_data  out  XLEN  quotient or remainder
- div_wb_rd_addr  out  REG_FILE_ADDR_WIDTH  destination
- div_wb_instr_tag  out  TAG_WIDTH  tag

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE; every output and internal register 0.
- IDLE: div_valid & ~pipe_flush → capture op, rd, tag, rem/unsign flags. Signed: magnitudes of both operands; record q_neg = sign(rs1) ^ sign(rs2), r_neg = sign(rs1). Unsigned: raw operands, q_neg = r_neg = 0.
- Fast paths from IDLE, straight to DONE with result preloaded:
  - divisor 0: quotient 0xFFFF_FFFF, remainder = rs1 (unmodified).
  - signed, rs1 = 0x8000_0000, rs2 = 0xFFFF_FFFF: quotient 0x8000_0000, remainder 0.
- Otherwise → CALC, count = 0, r = 0 (XLEN+1 bits), q = |dividend|.
- CALC, per cycle: t = {r[XLEN-1:0], q[XLEN-1]}; if t ≥ {0,|divisor|} then r = t − divisor, q = {q[XLEN-2:0],1}, else r = t, q = {q[XLEN-2:0],0}; count++. At count = XLEN−1 → DONE.
- DONE: quotient = q_neg ? −q : q; remainder = r_neg ? −r : r (XLEN bits, two's complement, wrap). div_wb_data = div_rem ? remainder : quotient; div_wb_valid = 1 for exactly this cycle; → IDLE.
- div_busy = 1 in CALC only; 0 in IDLE and DONE.
- div_valid in CALC/DONE is ignored (IDLE only accepts); IDU1 guarantees no issue while busy.
- rd_addr 0: computed and written back normally; reg file discards x0.
- pipe_flush in CALC or DONE: → IDLE next edge, div_wb_valid forced 0 that cycle, busy 0 next cycle. pipe_flush with div_valid in IDLE: not accepted.
- rst mid-operation: immediate return to IDLE, outputs 0, no writeback.

## Timing
- Cycle 0: div_valid sampled. Normal op: CALC cycles 1..XLEN (busy high, 32 cycles); DONE cycle XLEN+1 (wb_valid high, busy low). Issue-to-writeback latency XLEN+1 = 33.
- Fast path: DONE in cycle 1, busy never asserts, latency 1.
- busy rises cycle 1, matching IDU1 last-issued-div register; the stalled dependent in IDU1 receives forwarded result in the DONE cycle and issues next cycle.
- New div may be sampled in the DONE+1 cycle (IDLE); back-to-back throughput 34 cycles.
- wb outputs registered; div_wb_data/rd/tag hold last value when wb_valid = 0.

## Test plan
- DIVU 100/7 at cycle 0 → busy high cycles 1–32, cycle 33 wb_valid=1, data 14; REMU same operands → 2.
- DIV 0xFFFF_FFF9 (−7) / 2 → 0xFFFF_FFFD; REM → 0xFFFF_FFFF; DIVU same operands → 0x7FFF_FFFC.
- DIV 5/0 → wb at cycle 1 data 0xFFFF_FFFF, busy never high; REM 5/0 → 5; REMU 0xFFFF_FFFF/0 → 0xFFFF_FFFF.
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000 at cycle 1; REM → 0; DIVU same → 0 after 33 cycles.
- Issue DIV, pipe_flush at cycle 10 → busy 0 from cycle 11, no wb_valid ever; next div issued cycle 12 completes normally at cycle 45 with correct tag/rd.
- Assert rst at cycle 15 of a DIV → busy and wb outputs 0 immediately; after release no writeback; fresh DIVU 0xFFFF_FFFF/1 → 0xFFFF_FFFF.
